// File: rtl/wishbone_timeout_guard_pkg.sv
// rtl/wishbone_timeout_guard_pkg.sv - shared state encodings and defaults for the Wishbone timeout guard
package wishbone_timeout_guard_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_ERR   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

    // Error counter sticks at all-ones rather than wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/wishbone_timeout_guard.sv
// rtl/wishbone_timeout_guard.sv - Wishbone pass-through that error-terminates cycles no slave acks in time
module wishbone_timeout_guard
    import wishbone_timeout_guard_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned CW       = 16,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_m_cyc_i,
    input  logic        wbs_m_stb_i,
    input  logic        wbs_m_we_i,
    input  logic [3:0]  wbs_m_sel_i,
    input  logic [31:0] wbs_m_adr_i,
    input  logic [31:0] wbs_m_dat_i,
    output logic        wbs_m_ack_o,
    output logic [31:0] wbs_m_dat_o,
    output logic        wbs_s_cyc_o,
    output logic        wbs_s_stb_o,
    output logic        wbs_s_we_o,
    output logic [3:0]  wbs_s_sel_o,
    output logic [31:0] wbs_s_adr_o,
    output logic [31:0] wbs_s_dat_o,
    input  logic        wbs_s_ack_i,
    input  logic [31:0] wbs_s_dat_i,
    output logic        timeout_o,
    output logic [7:0]  err_cnt_o,
    output logic [31:0] err_adr_o
);

    logic          req;
    logic          at_limit;
    logic          pass;
    logic          live;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   shadow_adr_q, shadow_adr_d;
    logic [31:0]   err_adr_q, err_adr_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    assign req      = wbs_m_cyc_i & wbs_m_stb_i;
    assign at_limit = (cnt_q == CW'(TIMEOUT - 1));
    assign pass     = (state_q == ST_IDLE) || (state_q == ST_WAIT);
    assign live     = ~wb_rst_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req && !wbs_s_ack_i) state_d = ST_WAIT;
            ST_WAIT: begin
                // A slave ack on the final wait cycle still wins over the timeout.
                if (!req || wbs_s_ack_i) state_d = ST_IDLE;
                else if (at_limit)       state_d = ST_ERR;
            end
            ST_ERR:   state_d = ST_DRAIN;
            ST_DRAIN: if (!req) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = '0;
        if (state_q == ST_WAIT) cnt_d = cnt_q + CW'(1);
    end

    always_comb begin
        shadow_adr_d = shadow_adr_q;
        err_adr_d    = err_adr_q;
        err_cnt_d    = err_cnt_q;
        if (state_q == ST_IDLE && req && !wbs_s_ack_i) shadow_adr_d = wbs_m_adr_i;
        if (state_q == ST_ERR) begin
            err_adr_d = shadow_adr_q;
            err_cnt_d = sat_inc8(err_cnt_q);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            shadow_adr_q <= '0;
            err_adr_q    <= '0;
            err_cnt_q    <= '0;
        end else begin
            shadow_adr_q <= shadow_adr_d;
            err_adr_q    <= err_adr_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    // Every output is forced low while reset is held, even before the first clock edge.
    assign wbs_s_cyc_o = live & pass & wbs_m_cyc_i;
    assign wbs_s_stb_o = live & pass & wbs_m_stb_i;
    assign wbs_s_we_o  = live & wbs_m_we_i;
    assign wbs_s_sel_o = live ? wbs_m_sel_i : 4'h0;
    assign wbs_s_adr_o = live ? wbs_m_adr_i : 32'h0;
    assign wbs_s_dat_o = live ? wbs_m_dat_i : 32'h0;

    assign wbs_m_ack_o = live & (pass ? wbs_s_ack_i : (state_q == ST_ERR));
    assign wbs_m_dat_o = !live                 ? 32'h0 :
                         pass                  ? wbs_s_dat_i :
                         (state_q == ST_ERR)   ? ERR_DATA : 32'h0;

    assign timeout_o = live & (state_q == ST_ERR);
    assign err_cnt_o = live ? err_cnt_q : 8'h0;
    assign err_adr_o = live ? err_adr_q : 32'h0;

endmodule

// File: tb/tb_wishbone_timeout_guard.sv
// tb/tb_wishbone_timeout_guard.sv - self-checking bench for wishbone_timeout_guard
module tb_wishbone_timeout_guard;
    import wishbone_timeout_guard_pkg::*;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we, s_ack;
    logic [3:0]  sel;
    logic [31:0] adr, wdat, s_dat;
    logic        m_ack, s_cyc, s_stb, s_we, to;
    logic [3:0]  s_sel;
    logic [31:0] m_dat, s_adr, s_wdat, err_adr;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    wishbone_timeout_guard #(.TIMEOUT(T), .CW(16), .ERR_DATA(32'hDEADBEEF)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_m_cyc_i(cyc), .wbs_m_stb_i(stb), .wbs_m_we_i(we), .wbs_m_sel_i(sel),
        .wbs_m_adr_i(adr), .wbs_m_dat_i(wdat), .wbs_m_ack_o(m_ack), .wbs_m_dat_o(m_dat),
        .wbs_s_cyc_o(s_cyc), .wbs_s_stb_o(s_stb), .wbs_s_we_o(s_we), .wbs_s_sel_o(s_sel),
        .wbs_s_adr_o(s_adr), .wbs_s_dat_o(s_wdat), .wbs_s_ack_i(s_ack), .wbs_s_dat_i(s_dat),
        .timeout_o(to), .err_cnt_o(err_cnt), .err_adr_o(err_adr)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a transfer is "busy" for some age in cycles; at age T+1 it is
    // error-terminated, after which the master is ignored until it lets go of req.
    bit          m_busy = 0, m_hold = 0;
    int          m_age = 0, m_errcnt = 0;
    logic [31:0] m_shadow = '0, m_erradr = '0;

    logic        obs_ack, obs_to, obs_scyc;
    logic [31:0] obs_dat, obs_erradr;
    logic [7:0]  obs_errcnt;
    int          to_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic c, input logic s, input logic w, input logic [3:0] sl,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic k, input logic [31:0] sd);
        logic e_pass, e_ack, e_to, rq;
        logic [31:0] e_dat;
        @(negedge clk);
        cyc = c; stb = s; we = w; sel = sl; adr = a; wdat = wd; s_ack = k; s_dat = sd;
        #1;
        rq = c & s;
        if (rst) begin
            e_pass = 0; e_ack = 0; e_to = 0; e_dat = 0;
        end else if (m_hold) begin
            e_pass = 0; e_ack = 0; e_to = 0; e_dat = 0;
        end else if (m_busy && m_age == T + 1) begin
            e_pass = 0; e_ack = 1; e_to = 1; e_dat = 32'hDEADBEEF;
        end else begin
            e_pass = 1; e_ack = k; e_to = 0; e_dat = sd;
        end
        chk("m_ack",   32'(m_ack), 32'(e_ack));
        chk("m_dat",   m_dat, e_dat);
        chk("timeout", 32'(to), 32'(e_to));
        chk("s_cyc",   32'(s_cyc), 32'(!rst & e_pass & c));
        chk("s_stb",   32'(s_stb), 32'(!rst & e_pass & s));
        chk("s_we",    32'(s_we), 32'(!rst & w));
        chk("s_sel",   32'(s_sel), rst ? 32'h0 : 32'(sl));
        chk("s_adr",   s_adr, rst ? 32'h0 : a);
        chk("s_dat",   s_wdat, rst ? 32'h0 : wd);
        chk("err_cnt", 32'(err_cnt), rst ? 32'h0 : 32'(m_errcnt));
        chk("err_adr", err_adr, rst ? 32'h0 : m_erradr);
        obs_ack = m_ack; obs_dat = m_dat; obs_to = to; obs_scyc = s_cyc;
        obs_errcnt = err_cnt; obs_erradr = err_adr;
        if (to) to_seen++;
        @(posedge clk);
        if (rst) begin
            m_busy = 0; m_hold = 0; m_age = 0; m_errcnt = 0; m_erradr = '0;
        end else if (m_hold) begin
            if (!rq) m_hold = 0;
        end else if (m_busy && m_age == T + 1) begin
            m_busy = 0; m_hold = 1; m_erradr = m_shadow;
            m_errcnt = (m_errcnt < 255) ? m_errcnt + 1 : 255;
        end else if (m_busy) begin
            if (!rq || k) m_busy = 0;
            else m_age++;
        end else if (rq && !k) begin
            m_busy = 1; m_age = 1; m_shadow = a;
        end
    endtask

    task automatic rd(input logic r, input logic [31:0] a, input logic k, input logic [31:0] sd);
        step(r, r, 1'b0, 4'hF, a, 32'h0, k, sd);
    endtask

    typedef struct {
        logic        c;
        logic        k;
        logic [31:0] sd;
        logic        e_ack;
        logic [31:0] e_dat;
        logic        e_scyc;
        logic [7:0]  e_errcnt;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int ack_cycle;
        int t0;
        logic holding;
        int ack_mode;

        tbl[0] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 8'h0};
        tbl[1] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 8'h0};
        tbl[2] = '{1'b1, 1'b1, 32'h12345678,  1'b1, 32'h12345678,  1'b1, 8'h0};
        tbl[3] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 8'h0};
        tbl[4] = '{1'b1, 1'b1, 32'hA5A5A5A5,  1'b1, 32'hA5A5A5A5,  1'b1, 8'h0};
        tbl[5] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 8'h0};
        tbl[6] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 8'h0};

        rst = 1'b1;
        cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0; s_ack = 0; s_dat = 0;
        step(1'b1, 1'b1, 1'b1, 4'hF, 32'hFFFF0000, 32'h55AA55AA, 1'b1, 32'h77777777);
        chk("rst_ack", 32'(obs_ack), 32'h0);
        chk("rst_scyc", 32'(obs_scyc), 32'h0);
        chk("rst_errcnt", 32'(obs_errcnt), 32'h0);
        rd(1'b0, 32'h0, 1'b0, 32'h0);
        rst = 1'b0;

        // Case 1 plus zero-wait and abort patterns, expectations written out by hand.
        foreach (tbl[i]) begin
            rd(tbl[i].c, 32'h30000010, tbl[i].k, tbl[i].sd);
            chk($sformatf("tbl%0d_ack", i), 32'(obs_ack), 32'(tbl[i].e_ack));
            chk($sformatf("tbl%0d_dat", i), obs_dat, tbl[i].e_dat);
            chk($sformatf("tbl%0d_scyc", i), 32'(obs_scyc), 32'(tbl[i].e_scyc));
            chk($sformatf("tbl%0d_errcnt", i), 32'(obs_errcnt), 32'(tbl[i].e_errcnt));
        end

        // Case 2: unanswered read is error-acked in cycle T+1.
        to_seen = 0;
        ack_cycle = -1;
        rd(1'b1, 32'h30040000, 1'b0, 32'h0);
        for (int i = 1; i <= 40; i++) begin
            rd(1'b1, 32'h30040000, 1'b0, 32'h0);
            if (obs_ack) begin
                ack_cycle = i;
                chk("t2_dat", obs_dat, 32'hDEADBEEF);
                chk("t2_to", 32'(obs_to), 32'h1);
                break;
            end
        end
        chk("t2_ack_cycle", ack_cycle, 32'(T + 1));
        // Case 3: late slave ack while draining never reaches the master.
        rd(1'b1, 32'h30040000, 1'b1, 32'h11111111);
        chk("t3_drain_ack", 32'(obs_ack), 32'h0);
        chk("t2_errcnt", 32'(obs_errcnt), 32'h1);
        chk("t2_erradr", obs_erradr, 32'h30040000);
        rd(1'b0, 32'h0, 1'b0, 32'h0);
        chk("t3_drop_ack", 32'(obs_ack), 32'h0);
        chk("t2_to_pulses", to_seen, 32'h1);
        rd(1'b1, 32'h30000020, 1'b1, 32'h22222222);
        chk("t3_idle_ack", 32'(obs_ack), 32'h1);
        chk("t3_idle_dat", obs_dat, 32'h22222222);
        rd(1'b0, 32'h0, 1'b0, 32'h0);

        // Case 4: ack on the last wait cycle is a normal ack.
        to_seen = 0;
        rd(1'b1, 32'h30004000, 1'b0, 32'h0);
        for (int i = 1; i < T; i++) rd(1'b1, 32'h30004000, 1'b0, 32'h0);
        rd(1'b1, 32'h30004000, 1'b1, 32'hCAFEF00D);
        chk("t4_ack", 32'(obs_ack), 32'h1);
        chk("t4_dat", obs_dat, 32'hCAFEF00D);
        rd(1'b0, 32'h0, 1'b0, 32'h0);
        chk("t4_to", to_seen, 32'h0);
        chk("t4_errcnt", 32'(obs_errcnt), 32'h1);

        // Case 5: abort at cnt==5 then a fresh transfer gets the full wait budget.
        rd(1'b1, 32'h30005000, 1'b0, 32'h0);
        for (int i = 1; i <= 5; i++) rd(1'b1, 32'h30005000, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 4'hF, 32'h30005000, 32'h0, 1'b0, 32'h0);
        chk("t5_abort_ack", 32'(obs_ack), 32'h0);
        rd(1'b1, 32'h30005004, 1'b0, 32'h0);
        for (int i = 1; i < T; i++) rd(1'b1, 32'h30005004, 1'b0, 32'h0);
        rd(1'b1, 32'h30005004, 1'b1, 32'h0BADCAFE);
        chk("t5_reissue_ack", 32'(obs_ack), 32'h1);
        chk("t5_reissue_dat", obs_dat, 32'h0BADCAFE);
        chk("t5_to", to_seen, 32'h0);
        // Reset while waiting, with the master and a slave ack still active.
        rd(1'b1, 32'h30006000, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) rd(1'b1, 32'h30006000, 1'b0, 32'h0);
        rst = 1'b1;
        rd(1'b1, 32'h30006000, 1'b1, 32'h99999999);
        chk("t5_rst_ack", 32'(obs_ack), 32'h0);
        chk("t5_rst_dat", obs_dat, 32'h0);
        chk("t5_rst_scyc", 32'(obs_scyc), 32'h0);
        chk("t5_rst_errcnt", 32'(obs_errcnt), 32'h0);
        rst = 1'b0;
        rd(1'b1, 32'h30006000, 1'b0, 32'h0);
        chk("t5_post_errcnt", 32'(obs_errcnt), 32'h0);
        chk("t5_post_scyc", 32'(obs_scyc), 32'h1);
        rd(1'b0, 32'h0, 1'b0, 32'h0);

        // Randomized traffic against the model.
        holding = 1'b0;
        ack_mode = 0;
        for (int n = 0; n < 2000; n++) begin
            if (n % 100 == 0) ack_mode = $urandom_range(0, 1);
            if (holding) holding = ($urandom_range(0, 11) != 0);
            else         holding = ($urandom_range(0, 1) != 0);
            step(holding, holding ? ($urandom_range(0, 9) != 0) : 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, $urandom,
                 ack_mode == 0 ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 29) == 0),
                 $urandom);
        end
        rd(1'b0, 32'h0, 1'b0, 32'h0);
        rd(1'b0, 32'h0, 1'b0, 32'h0);

        // Case 6: 300 timeouts from a cleared counter saturate it.
        rst = 1'b1;
        rd(1'b0, 32'h0, 1'b0, 32'h0);
        rst = 1'b0;
        for (int n = 0; n < 300; n++) begin
            t0 = to_seen;
            rd(1'b1, 32'h30000000 + n, 1'b0, 32'h0);
            for (int i = 0; i < 40 && to_seen == t0; i++) rd(1'b1, 32'h30000000 + n, 1'b0, 32'h0);
            if (to_seen == t0) chk($sformatf("t6_timeout_%0d", n), 32'h0, 32'h1);
            rd(1'b1, 32'h30000000 + n, 1'b0, 32'h0);
            rd(1'b0, 32'h0, 1'b0, 32'h0);
        end
        rd(1'b0, 32'h0, 1'b0, 32'h0);
        chk("t6_errcnt", 32'(obs_errcnt), 32'hFF);
        chk("t6_erradr", obs_erradr, 32'h3000012B);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
